// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - Wishbone B4 point-to-point link used on each side of the arbiter
interface wb_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_W-1:0]     adr;
  logic [DATA_W-1:0]     dat_w;
  logic [DATA_W/8-1:0]   sel;
  logic                  ack;
  logic                  err;
  logic [DATA_W-1:0]     dat_r;

  // err only originates in the arbiter's watchdog, so the downstream link never carries it
  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, err, dat_r
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - Two-master Wishbone B4 arbiter with cycle-held grant, round-robin and watchdog
module wb_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  wb_bus_arbiter_if.slave  m0,
  wb_bus_arbiter_if.slave  m1,
  wb_bus_arbiter_if.master s,
  output logic [1:0]       grant
);

  // State encoding doubles as the one-hot grant vector {M1,M0}
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]          state, state_nx;
  logic                last_owner, last_owner_nx;
  logic [CNT_W-1:0]    wd_cnt, wd_cnt_nx;

  logic                owned, sel_m1;
  logic                own_cyc, own_stb, own_we, other_cyc;
  logic [ADDR_W-1:0]   own_adr;
  logic [DATA_W-1:0]   own_dat_w;
  logic [DATA_W/8-1:0] own_sel;
  logic                req_stb, stalled, expire;
  logic                s_cyc_int;

  assign owned  = (state != IDLE);
  assign sel_m1 = (state == OWN1);

  assign own_cyc   = sel_m1 ? m1.cyc   : m0.cyc;
  assign own_stb   = sel_m1 ? m1.stb   : m0.stb;
  assign own_we    = sel_m1 ? m1.we    : m0.we;
  assign own_adr   = sel_m1 ? m1.adr   : m0.adr;
  assign own_dat_w = sel_m1 ? m1.dat_w : m0.dat_w;
  assign own_sel   = sel_m1 ? m1.sel   : m0.sel;
  assign other_cyc = sel_m1 ? m0.cyc   : m1.cyc;

  assign req_stb = owned && own_cyc && own_stb;
  assign stalled = req_stb && !s.ack;
  // Expiry fires on the TIMEOUT-th consecutive unacknowledged strobe clock
  assign expire  = WD_EN && stalled && (wd_cnt == WD_LAST);

  assign s_cyc_int = owned && own_cyc && !expire;
  assign s.cyc     = s_cyc_int;
  assign s.stb     = s_cyc_int && own_stb;
  assign s.we      = s_cyc_int && own_we;
  assign s.sel     = s_cyc_int ? own_sel : '0;
  assign s.adr     = owned ? own_adr : '0;
  assign s.dat_w   = owned ? own_dat_w : '0;

  assign m0.ack   = (state == OWN0) && s.ack && !expire;
  assign m1.ack   = (state == OWN1) && s.ack && !expire;
  assign m0.err   = (state == OWN0) && expire;
  assign m1.err   = (state == OWN1) && expire;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

  assign grant = state;

  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    wd_cnt_nx     = '0;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_nx = last_owner ? OWN0 : OWN1;
        end else if (m0.cyc) begin
          state_nx = OWN0;
        end else if (m1.cyc) begin
          state_nx = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (expire) begin
          state_nx      = IDLE;
          last_owner_nx = sel_m1;
        end else if (!own_cyc) begin
          // Hand straight over to a waiting master without passing through IDLE
          last_owner_nx = sel_m1;
          if (other_cyc) begin
            state_nx = sel_m1 ? OWN0 : OWN1;
          end else begin
            state_nx = IDLE;
          end
        end else if (WD_EN && stalled) begin
          wd_cnt_nx = wd_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      wd_cnt     <= '0;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      wd_cnt     <= wd_cnt_nx;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - Self-checking bench for wb_bus_arbiter with directed and random traffic
module tb_wb_bus_arbiter;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  wb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  wb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  wb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  assign s_bus.err = 1'b0;

  wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus (-1 none), who owned it last, consecutive unacked strobes
  int mo_owner;
  int mo_last;
  int mo_stall;

  logic [1:0]  ob_grant;
  logic        ob_scyc, ob_ack0, ob_ack1, ob_err0, ob_err1;
  logic [31:0] ob_dat0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (n == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
      m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
      m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
    end
  endtask

  task automatic model_reset();
    mo_owner = -1;
    mo_last  = 1;
    mo_stall = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic cycle();
    logic        c[2];
    logic        b[2];
    logic        w[2];
    logic [31:0] a[2];
    logic [3:0]  sl[2];
    logic        ack, mc, to, live;
    int          o;
    @(negedge clk);
    c[0] = m0_bus.cyc; c[1] = m1_bus.cyc;
    b[0] = m0_bus.stb; b[1] = m1_bus.stb;
    w[0] = m0_bus.we;  w[1] = m1_bus.we;
    a[0] = m0_bus.adr; a[1] = m1_bus.adr;
    sl[0] = m0_bus.sel; sl[1] = m1_bus.sel;
    ack = s_bus.ack;
    o  = mo_owner;
    mc = 1'b0;
    to = 1'b0;
    if (o >= 0) begin
      mc = c[o];
      to = mc && b[o] && !ack && (mo_stall + 1 == TMO);
    end
    live = (o >= 0) && mc && !to;
    ob_grant = grant;   ob_scyc = s_bus.cyc;
    ob_ack0 = m0_bus.ack; ob_ack1 = m1_bus.ack;
    ob_err0 = m0_bus.err; ob_err1 = m1_bus.err;
    ob_dat0 = m0_bus.dat_r;
    chk("grant", grant, (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10));
    chk("s_cyc", s_bus.cyc, live);
    chk("s_stb", s_bus.stb, live && b[o]);
    if (live) begin
      chk("s_adr", s_bus.adr, a[o]);
      chk("s_we", s_bus.we, w[o]);
      chk("s_sel", s_bus.sel, sl[o]);
    end
    chk("m0_ack", m0_bus.ack, (o == 0) && !to && ack);
    chk("m1_ack", m1_bus.ack, (o == 1) && !to && ack);
    chk("m0_err", m0_bus.err, (o == 0) && to);
    chk("m1_err", m1_bus.err, (o == 1) && to);
    chk("m1_dat_r", m1_bus.dat_r, s_bus.dat_r);
    @(posedge clk);
    if (o < 0) begin
      if (c[0] && c[1]) mo_owner = 1 - mo_last;
      else if (c[0])    mo_owner = 0;
      else if (c[1])    mo_owner = 1;
      mo_stall = 0;
    end else if (to || !mc) begin
      mo_last  = o;
      mo_stall = 0;
      mo_owner = (!to && c[1 - o]) ? 1 - o : -1;
    end else begin
      mo_stall = (b[o] && !ack) ? mo_stall + 1 : 0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_bus.ack = 1'b0;
    s_bus.dat_r = 32'h0;
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_bus.cyc, 1'b0);
    chk("rst_s_stb", s_bus.stb, 1'b0);
    chk("rst_acks", {m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // M0 single read, slave answers two clocks after the request
    drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    cycle();
    cycle();
    chk("t1_grant", ob_grant, 2'b01);
    chk("t1_no_early_ack", ob_ack0, 1'b0);
    s_bus.ack = 1'b1; s_bus.dat_r = 32'hDEADBEEF;
    cycle();
    chk("t1_ack", ob_ack0, 1'b1);
    chk("t1_dat_r", ob_dat0, 32'hDEADBEEF);
    chk("t1_m1_ack", ob_ack1, 1'b0);
    s_bus.ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("t1_idle", ob_grant, 2'b00);

    // Simultaneous requests after reset, hand-over, then round-robin
    rst = 1'b1; model_reset(); @(posedge clk); #1; rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("t2_first_m0", ob_grant, 2'b01);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("t2_handover_m1", ob_grant, 2'b10);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("t2_idle", ob_grant, 2'b00);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("t2_rr_m0", ob_grant, 2'b01);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();

    // M1 four-beat pipelined write, M0 requests mid-burst
    drive(1, 1'b1, 1'b1, 1'b1, 32'h200, 32'hA0, 4'hF);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      if (i == 1) drive(0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
      s_bus.ack = 1'b1;
      cycle();
      chk("t3_burst_grant", ob_grant, 2'b10);
      chk("t3_burst_ack", ob_ack1, 1'b1);
      chk("t3_m0_blocked", ob_ack0, 1'b0);
    end
    s_bus.ack = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("t3_m0_after", ob_grant, 2'b01);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();

    // Watchdog on a slave that never acks M0, with M1 waiting
    drive(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    cycle();
    drive(1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
    for (int k = 1; k <= TMO; k++) begin
      cycle();
      chk("t4_err_timing", ob_err0, (k == TMO));
      chk("t4_s_cyc", ob_scyc, (k != TMO));
    end
    cycle();
    chk("t4_idle_after", ob_grant, 2'b00);
    cycle();
    chk("t4_m1_granted", ob_grant, 2'b10);

    // Asynchronous reset while M1 strobes mid-stall
    drive(1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h55, 4'h3);
    for (int k = 0; k < 5; k++) cycle();
    s_bus.ack = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_grant", grant, 2'b00);
    chk("t5_s_cyc", s_bus.cyc, 1'b0);
    chk("t5_s_stb", s_bus.stb, 1'b0);
    chk("t5_ack_err", {m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err}, 4'b0000);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    s_bus.ack = 1'b0;
    cycle();
    for (int k = 1; k <= TMO; k++) begin
      cycle();
      if (k == 1) chk("t5_tie_m0", ob_grant, 2'b01);
      chk("t5_wd_fresh", ob_err0, (k == TMO));
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycle();

    // Stray slave ack while idle
    s_bus.ack = 1'b1; s_bus.dat_r = 32'h12345678;
    cycle();
    chk("t6_ack_ignored", {ob_ack0, ob_ack1}, 2'b00);
    s_bus.ack = 1'b0;
    cycle();
    chk("t6_still_idle", ob_grant, 2'b00);

    // Random traffic against the model, alternating responsive and sluggish slave phases
    for (int i = 0; i < 4000; i++) begin
      int ack_div;
      ack_div = ((i / 200) % 2 == 1) ? 12 : 2;
      if (m0_bus.cyc) m0_bus.cyc = ($urandom_range(5, 0) != 0);
      else            m0_bus.cyc = ($urandom_range(2, 0) == 0);
      if (m1_bus.cyc) m1_bus.cyc = ($urandom_range(5, 0) != 0);
      else            m1_bus.cyc = ($urandom_range(2, 0) == 0);
      m0_bus.stb = ($urandom_range(3, 0) != 0);
      m1_bus.stb = ($urandom_range(3, 0) != 0);
      m0_bus.we = 1'($urandom); m1_bus.we = 1'($urandom);
      m0_bus.adr = $urandom; m1_bus.adr = $urandom;
      m0_bus.dat_w = $urandom; m1_bus.dat_w = $urandom;
      m0_bus.sel = 4'($urandom); m1_bus.sel = 4'($urandom);
      s_bus.ack = ($urandom_range(ack_div - 1, 0) == 0);
      s_bus.dat_r = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
